// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the CPU/DMA data-memory bus arbiter.
package mem_bus_pkg;

  // Arbiter state encoding (2-bit).
  typedef enum logic [1:0] {
    S_CPU     = 2'd0,
    S_HANDOFF = 2'd1,
    S_DMA     = 2'd2,
    S_RETURN  = 2'd3
  } arb_state_e;

  // Default number of DMA words accepted per grant.
  localparam int MAX_BURST_DEFAULT  = 8;
  // Default number of CPU-busy cycles a DMA request waits before a forced handoff.
  localparam int STARVE_LIM_DEFAULT = 4;

  // A DMA cycle with both strobes high is a write.
  function automatic logic dma_write_strobe(input logic rd, input logic wr);
    return wr;
  endfunction

  // A DMA read reaches memory only when no write is requested alongside it.
  function automatic logic dma_read_strobe(input logic rd, input logic wr);
    return rd & ~wr;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_burst_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module burst_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count up on inc, hold at MAX, drop to zero on clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != W'(MAX))) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a single data-memory port between the CPU and a DMA master.
// The CPU owns the bus by default; DMA gets bounded bursts, bracketed by
// one-cycle handoff/return states during which the CPU is stalled.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_BURST  = MAX_BURST_DEFAULT,
  parameter int STARVE_LIM = STARVE_LIM_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          dma_req,
  input  logic          dma_rd,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          dma_grant,
  output logic          dma_ack,
  output logic          check_out
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(STARVE_LIM + 1);

  arb_state_e    state_r;
  logic          cooldown_r;
  logic          check_out_r;

  logic [BW-1:0] burst_cnt_s;
  logic [WW-1:0] wait_cnt_s;
  logic          cpu_busy_s;
  logic          dma_ack_s;
  logic          starve_s;
  logic          handoff_s;
  logic          burst_done_s;
  logic          dma_exit_s;
  logic          burst_clr_s;
  logic          wait_clr_s;

  assign cpu_busy_s   = cpu_rd | cpu_wr;
  assign dma_ack_s    = (state_r == S_DMA) & (dma_rd | dma_wr);
  assign starve_s     = (wait_cnt_s >= WW'(STARVE_LIM));
  // An idle CPU yields at once; a busy CPU yields only once DMA has starved.
  // Cooldown keeps a forced handoff off the CPU's first cycle back.
  assign handoff_s    = dma_req & (~cpu_busy_s | (starve_s & ~cooldown_r));
  // The last permitted word is still accepted in the cycle the limit is hit.
  assign burst_done_s = dma_ack_s & (burst_cnt_s == BW'(MAX_BURST - 1));
  assign dma_exit_s   = ~dma_req | burst_done_s;
  assign burst_clr_s  = (state_r != S_DMA);
  assign wait_clr_s   = (state_r != S_CPU) | ~dma_req;

  burst_counter #(.MAX(MAX_BURST), .W(BW)) u_burst_cnt (
    .clk (clk),
    .rst (rst),
    .clr (burst_clr_s),
    .inc (dma_ack_s),
    .cnt (burst_cnt_s)
  );

  burst_counter #(.MAX(STARVE_LIM), .W(WW)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (wait_clr_s),
    .inc (cpu_busy_s),
    .cnt (wait_cnt_s)
  );

  // Arbitration FSM with registered stall and cooldown flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_CPU;
      cooldown_r  <= 1'b0;
      check_out_r <= 1'b0;
    end else begin
      case (state_r)
        S_CPU: begin
          cooldown_r <= 1'b0;
          if (handoff_s) begin
            state_r     <= S_HANDOFF;
            check_out_r <= 1'b1;
          end else begin
            state_r     <= S_CPU;
            check_out_r <= 1'b0;
          end
        end
        S_HANDOFF: begin
          state_r     <= S_DMA;
          cooldown_r  <= 1'b0;
          check_out_r <= 1'b1;
        end
        S_DMA: begin
          cooldown_r  <= 1'b0;
          check_out_r <= 1'b1;
          if (dma_exit_s) begin
            state_r <= S_RETURN;
          end else begin
            state_r <= S_DMA;
          end
        end
        S_RETURN: begin
          state_r     <= S_CPU;
          cooldown_r  <= 1'b1;
          check_out_r <= 1'b0;
        end
        default: begin
          state_r     <= S_CPU;
          cooldown_r  <= 1'b0;
          check_out_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory port mux: CPU in S_CPU, DMA in S_DMA, quiet otherwise.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    dma_grant = 1'b0;
    dma_ack   = 1'b0;
    case (state_r)
      S_CPU: begin
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      S_DMA: begin
        mem_rd    = dma_read_strobe(dma_rd, dma_wr);
        mem_wr    = dma_write_strobe(dma_rd, dma_wr);
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        dma_grant = 1'b1;
        dma_ack   = dma_ack_s;
      end
      default: begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        dma_grant = 1'b0;
        dma_ack   = 1'b0;
      end
    endcase
  end

  assign check_out = check_out_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: CPU passthrough, short bursts,
// burst-limit regrant, starvation handoff, reset mid-burst, rd+wr priority.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        dma_req, dma_rd, dma_wr;
  logic [31:0] dma_addr, dma_wdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic        dma_grant, dma_ack, check_out;

  int tests = 0;
  int fails = 0;

  mem_bus_arbiter #(.AW(32), .DW(32), .MAX_BURST(8), .STARVE_LIM(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .dma_req   (dma_req),
    .dma_rd    (dma_rd),
    .dma_wr    (dma_wr),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .dma_grant (dma_grant),
    .dma_ack   (dma_ack),
    .check_out (check_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_rd = 1'b0; dma_wr = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
  endtask

  int          hi, acks, grants, a1, a2, nacks, seg;
  logic [18:0] pat;

  initial begin
    idle_inputs();
    rst = 1'b1;
    #12;
    chk("rst_check_out", {31'h0, check_out}, 32'h0);
    chk("rst_grant",     {31'h0, dma_grant}, 32'h0);
    chk("rst_ack",       {31'h0, dma_ack},   32'h0);
    chk("rst_mem_rd",    {31'h0, mem_rd},    32'h0);
    chk("rst_mem_wr",    {31'h0, mem_wr},    32'h0);
    chk("rst_mem_addr",  mem_addr,           32'h0);
    rst = 1'b0;

    // CPU passthrough
    cpu_wr = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'hDEAD;
    #1;
    chk("cpu_mem_wr",    {31'h0, mem_wr},    32'h1);
    chk("cpu_mem_addr",  mem_addr,           32'h44);
    chk("cpu_mem_wdata", mem_wdata,          32'hDEAD);
    chk("cpu_grant",     {31'h0, dma_grant}, 32'h0);
    tick();
    chk("cpu_check_out", {31'h0, check_out}, 32'h0);
    idle_inputs();

    // Three-word DMA write burst with an idle CPU
    dma_req = 1'b1;
    #1;
    chk("b3_pre_check_out", {31'h0, check_out}, 32'h0);
    tick();
    hi = 0; acks = 0;
    dma_wr = 1'b1; dma_addr = 32'h100; dma_wdata = 32'h1;
    #1;
    chk("b3_ho_check_out", {31'h0, check_out}, 32'h1);
    chk("b3_ho_mem_wr",    {31'h0, mem_wr},    32'h0);
    chk("b3_ho_ack",       {31'h0, dma_ack},   32'h0);
    chk("b3_ho_mem_addr",  mem_addr,           32'h0);
    hi = hi + int'(check_out);
    for (int i = 0; i < 3; i++) begin
      tick();
      dma_addr  = 32'h100 + 32'(4 * i);
      dma_wdata = 32'(i + 1);
      dma_req   = (i < 2) ? 1'b1 : 1'b0;
      #1;
      chk("b3_mem_wr",   {31'h0, mem_wr},    32'h1);
      chk("b3_mem_addr", mem_addr,           32'h100 + 32'(4 * i));
      chk("b3_grant",    {31'h0, dma_grant}, 32'h1);
      hi   = hi + int'(check_out);
      acks = acks + int'(dma_ack);
    end
    tick();
    idle_inputs();
    #1;
    chk("b3_ret_check_out", {31'h0, check_out}, 32'h1);
    chk("b3_ret_mem_wr",    {31'h0, mem_wr},    32'h0);
    hi = hi + int'(check_out);
    tick();
    hi = hi + int'(check_out);
    chk("b3_stall_cycles", 32'(hi),   32'd5);
    chk("b3_acks",         32'(acks), 32'd3);
    tick();

    // Twelve reads with dma_req held: 8 acks, 1 CPU cycle, regrant, 4 acks
    pat = 19'h0; a1 = 0; a2 = 0; nacks = 0; seg = 0;
    for (int c = 0; c < 19; c++) begin
      dma_req  = (nacks < 11) ? 1'b1 : 1'b0;
      dma_rd   = 1'b1;
      dma_addr = 32'h200 + 32'(4 * nacks);
      #1;
      pat = {pat[17:0], check_out};
      if (dma_ack) begin
        chk("b12_mem_addr", mem_addr, 32'h200 + 32'(4 * nacks));
        nacks++;
        if (seg == 0) a1++; else a2++;
      end
      if (!check_out && a1 > 0) seg = 1;
      tick();
    end
    idle_inputs();
    chk("b12_stall_pattern", {13'h0, pat}, {13'h0, 1'b0, 10'h3FF, 1'b0, 6'h3F, 1'b0});
    chk("b12_first_acks",  32'(a1), 32'd8);
    chk("b12_second_acks", 32'(a2), 32'd4);

    // CPU busy reading; DMA forced in after starvation limit
    cpu_rd = 1'b1; cpu_addr = 32'h300; dma_req = 1'b1;
    #1;
    chk("st_mem_rd",   {31'h0, mem_rd}, 32'h1);
    chk("st_mem_addr", mem_addr,        32'h300);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("st_wait_check_out", {31'h0, check_out}, 32'h0);
    end
    tick();
    chk("st_forced_check_out", {31'h0, check_out}, 32'h1);
    chk("st_ho_mem_rd",        {31'h0, mem_rd},    32'h0);
    idle_inputs();
    tick();
    chk("st_dma_grant", {31'h0, dma_grant}, 32'h1);
    chk("st_dma_ack",   {31'h0, dma_ack},   32'h0);
    tick();
    tick();
    tick();

    // One-cycle dma_req pulse with idle CPU
    dma_req = 1'b1;
    tick();
    dma_req = 1'b0;
    hi = 0; acks = 0; grants = 0;
    for (int k = 0; k < 5; k++) begin
      hi     = hi + int'(check_out);
      acks   = acks + int'(dma_ack);
      grants = grants + int'(dma_grant);
      tick();
    end
    chk("pulse_stall_cycles", 32'(hi),     32'd3);
    chk("pulse_acks",         32'(acks),   32'd0);
    chk("pulse_grant_cycles", 32'(grants), 32'd1);

    // dma_rd and dma_wr together resolve to a write
    dma_req = 1'b1;
    tick();
    tick();
    dma_rd = 1'b1; dma_wr = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h55; dma_req = 1'b0;
    #1;
    chk("rw_mem_wr",   {31'h0, mem_wr},  32'h1);
    chk("rw_mem_rd",   {31'h0, mem_rd},  32'h0);
    chk("rw_mem_addr", mem_addr,         32'h20);
    chk("rw_ack",      {31'h0, dma_ack}, 32'h1);
    idle_inputs();
    tick();
    tick();
    tick();

    // Reset asserted during the third burst word
    dma_req = 1'b1;
    tick();
    tick();
    dma_wr = 1'b1;
    for (int w = 0; w < 2; w++) begin
      dma_addr = 32'h400 + 32'(4 * w);
      tick();
    end
    dma_addr = 32'h408;
    #1;
    chk("rm_pre_ack", {31'h0, dma_ack}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("rm_check_out", {31'h0, check_out}, 32'h0);
    chk("rm_grant",     {31'h0, dma_grant}, 32'h0);
    chk("rm_ack",       {31'h0, dma_ack},   32'h0);
    chk("rm_mem_wr",    {31'h0, mem_wr},    32'h0);
    chk("rm_mem_rd",    {31'h0, mem_rd},    32'h0);
    chk("rm_mem_addr",  mem_addr,           32'h0);
    idle_inputs();
    #3;
    rst = 1'b0;
    tick();
    chk("rm_after_check_out", {31'h0, check_out}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
